// File: rtl/cpu_sequencer_pkg.sv
// Shared types and default widths for the multi-cycle fetch/execute sequencer.
package seq_def;

  localparam int PC_W_DEFAULT  = 10;
  localparam int CNT_W_DEFAULT = 16;
  localparam int INSTR_W       = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    MEM_WAIT,
    HALTED
  } SeqState;

endpackage

// File: rtl/cpu_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves q_d unassigned (no latch).
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer: owns PC and instruction register, gates
// register and memory side effects so each commits once per instruction.
module cpu_sequencer
  import seq_def::*;
#(
  parameter int PC_W  = PC_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PC_W-1:0]    start_addr,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  input  logic               ctrl_branch,
  input  logic               take_branch,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt,
  input  logic               ctrl_mem_read,
  input  logic               ctrl_mem_write,
  input  logic               ctrl_reg_write,
  output logic               reg_we,
  output logic               mem_req,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   instr_count
);

  SeqState            state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_op;
  logic               retire;
  logic               cnt_clr;

  assign mem_op = ctrl_mem_read | ctrl_mem_write;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    mem_we_d = mem_we_q;
    retire   = 1'b0;
    cnt_clr  = 1'b0;

    case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_d    = start_addr;
          cnt_clr = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH:  state_d = DECODE;
      DECODE: begin
        instr_d = imem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        if (!mem_op || mem_ready) begin
          retire = 1'b1;
        end else begin
          // Capture the write qualifier so it stays steady for the whole wait.
          mem_we_d = ctrl_mem_write;
          state_d  = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) retire = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (retire) begin
      if (halt) begin
        state_d = HALTED;
      end else begin
        state_d = FETCH;
        pc_d    = (ctrl_branch && take_branch) ? branch_target : pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      mem_we_q <= mem_we_d;
    end
  end

  // Strobes decode straight from state so reset drops them asynchronously.
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign busy        = (state_q == FETCH) || (state_q == DECODE) ||
                       (state_q == EXEC)  || (state_q == MEM_WAIT);
  assign done        = (state_q == HALTED);
  assign mem_req     = ((state_q == EXEC) && mem_op) || (state_q == MEM_WAIT);
  assign mem_we      = (state_q == EXEC)     ? ctrl_mem_write :
                       (state_q == MEM_WAIT) ? mem_we_q : 1'b0;
  assign reg_we      = retire & ctrl_reg_write;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (busy),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (retire),
    .q     (instr_count)
  );

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/execute sequencer for the 9-bit core. It owns the program counter and instruction register, and steps each instruction through fetch, decode and execute. Memory operations stretch execute with a request/ready handshake on data memory. Register-file and memory side effects are gated so they commit exactly once per instruction. It sits between instruction memory, the decode/control logic and data memory, and reports halt and performance counts.

## Interface
- PC_W, 10: program counter / instruction address width
- CNT_W, 16: width of the cycle and retired-instruction counters
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous active-low
- start  in  1  begin run from start_addr; honoured only in IDLE or HALTED
- start_addr  in  PC_W  first instruction address
- imem_addr  out  PC_W  instruction memory address; synchronous read, 1-cycle latency
- imem_rdata  in  9  instruction memory read data
- instruction  out  9  instruction register, drives decode
- ctrl_branch, take_branch  in  1 each  from decode: branch instruction, branch condition met
- branch_target  in  PC_W  absolute target, from the LUT path
- halt  in  1  decoded halt instruction
- ctrl_mem_read, ctrl_mem_write  in  1 each  decoded memory access
- ctrl_reg_write  in  1  decoded register write
- reg_we  out  1  gated register-file write enable
- mem_req  out  1  data memory request
- mem_we  out  1  data memory write qualifier, valid with mem_req
- mem_ready  in  1  data memory completion
- busy  out  1  high in FETCH/DECODE/EXEC/MEM_WAIT
- done  out  1  high in HALTED
- cycle_count  out  CNT_W  cycles spent busy; saturating
- instr_count  out  CNT_W  instructions retired; saturating

## Operation
- **Reset values:** state IDLE; pc 0; instruction 0; counters 0; all strobes 0.
- **IDLE:** waits for start. On start: pc <= start_addr, both counters cleared, go to FETCH.
- **FETCH:** imem_addr = pc for one cycle, then go to DECODE.
- **DECODE:** at the end of the cycle, instruction <= imem_rdata, then go to EXEC. Decode inputs are valid only in EXEC and MEM_WAIT.
- **EXEC, no memory access** (ctrl_mem_read = ctrl_mem_write = 0): reg_we = ctrl_reg_write, then the instruction retires.
- **EXEC, memory access:**
  - mem_req = 1 and mem_we = ctrl_mem_write.
  - If mem_ready = 1 in the same cycle, the instruction retires now; otherwise go to MEM_WAIT.
- **MEM_WAIT:** mem_req and mem_we are held steady. On the first cycle with mem_ready = 1:
  - reg_we = ctrl_reg_write;
  - the instruction retires.
  - No timeout.
- **Retire:**
  - instr_count increments.
  - PC update priority:
    1. halt: pc unchanged, go to HALTED;
    2. ctrl_branch & take_branch: pc <= branch_target;
    3. otherwise pc <= pc+1, wrapping modulo 2^PC_W.
  - Then go to FETCH.
  - A halt combined with a memory access still completes the handshake before halting.
- **HALTED:** done = 1 and pc holds. start behaves as in IDLE.
- **Ignored inputs:**
  - start while busy.
  - mem_ready outside EXEC/MEM_WAIT.
  - Decode inputs outside EXEC/MEM_WAIT.
- **Counters:** cycle_count increments on every busy cycle; both counters saturate at all-ones.
- **Reset mid-operation:** returns to the reset state immediately. Any pending mem_req drops asynchronously; the memory side aborts on reset.

## Timing
- Non-memory instruction: 3 cycles.
- Memory instruction: 3 + N cycles, where N is the number of MEM_WAIT cycles before mem_ready.
- reg_we is a single-cycle pulse per instruction.
- mem_req is never high for more than one transaction without an intervening FETCH.
- imem_addr changes only at the FETCH entry edge.
- done rises the cycle after the halting instruction retires.

## Structure
- Package seq_def:
  - state enum SeqState {IDLE, FETCH, DECODE, EXEC, MEM_WAIT, HALTED};
  - default PC_W and CNT_W constants.
- Sub-module sat_counter (parameter W; ports clr, inc, q), instanced twice for cycle_count and instr_count.
- The FSM and PC logic stay in cpu_sequencer.

## Test plan
- **Reset, then start with start_addr = 0x010 and non-memory instructions:**
  - imem_addr = 0x010, 0x011, 0x012 every 3 cycles;
  - one reg_we pulse per instruction in EXEC;
  - instr_count = 3 after 9 cycles.
- **Branch taken, branch_target = 0x005:** the next imem_addr is 0x005. Not taken: pc+1. pc = 0x3FF with no branch wraps to 0x000.
- **Load with mem_ready delayed 4 cycles:**
  - mem_req high for 5 cycles, mem_we = 0;
  - reg_we pulses only on the mem_ready cycle;
  - instruction latency 7 cycles.
- **Store with mem_ready already high in EXEC:** mem_req for 1 cycle, mem_we = 1, no MEM_WAIT, latency 3.
- **Halt at pc 0x020:**
  - done rises the next cycle, pc stays 0x020, busy = 0;
  - start while busy earlier had no effect;
  - start in HALTED restarts from start_addr with counters cleared.
- **Edge cases:**
  - rst_n low during MEM_WAIT clears mem_req asynchronously and returns to IDLE.
  - Forcing instr_count to 0xFFFF, one more retire keeps it at 0xFFFF.
